sipo_load_ctrl: RTL and testbench
=================================

Name: sipo_load_ctrl

Overview:
- Sequencer for the column SIPO shift register in the mixed-signal SRAM datapath.
- Accepts a parallel column word from an upstream requester over a valid/ready handshake.
- Serializes the word MSB-first onto the SIPO serial input while pulsing shift for COLS cycles. Then issues a one-cycle load to transfer the word to the SIPO parallel outputs, waits a programmable settle time for the analog array, and reports completion.

Parameters:
- COLS, 16: word width; must equal the SIPO COLS; legal range ≥ 2.
- SETTLE_CYC, 2: idle cycles after load before completion; 0 is legal.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: upstream word valid.
- in_ready, output, 1: controller can accept a word.
- in_data, input, COLS: column word; bit COLS-1 is shifted first.
- serial_out, output, 1: drives SIPO serial_in.
- shift, output, 1: drives SIPO shift.
- load, output, 1: drives SIPO load.
- busy, output, 1: sequence in progress (any state other than IDLE).
- done, output, 1: one-cycle completion pulse.

Behaviour:
- Reset: one clock, synchronous, active-high. This fixed decision applies to the whole block.
- Reset values: state IDLE, counters 0, word register 0. Outputs: in_ready=1, serial_out=0, shift=0, load=0, busy=0, done=0.
- Reset mid-sequence: aborts on the next edge, no further shift/load pulses, prefetch buffer cleared. SIPO contents are undefined afterwards.
- All outputs are registered or decoded from registered state only; there is no combinational path from in_valid to any output.
- FSM states: IDLE, SHIFT, LOAD, SETTLE.
- IDLE: in_ready=1. On in_valid&&in_ready, capture in_data and go to SHIFT.
- SHIFT: exactly COLS cycles, shift=1. In shift cycle i (i=0..COLS-1), serial_out = word[COLS-1-i]. A down-counter of width $clog2(COLS) wraps from 0 to LOAD. After COLS shifts the SIPO register equals the word.
- LOAD: 1 cycle, load=1, shift=0, serial_out=0. Next state is SETTLE if SETTLE_CYC>0, else IDLE.
- SETTLE: SETTLE_CYC cycles, all strobes 0, then IDLE.
- shift and load are never high in the same cycle.
- done=1 for exactly the first cycle after LOAD/SETTLE completes, i.e. the cycle the FSM re-enters IDLE.
- Latency: handshake at T, shift T+1..T+COLS, load T+COLS+1, done T+COLS+2+SETTLE_CYC.
- A new handshake is legal in the done cycle.
- in_data is ignored whenever in_ready=0. in_valid may drop without penalty while not accepted.

Optional Feature:
- Macro: SIPO_LOAD_CTRL_PREFETCH_EN.
- Defined:
  - One-entry holding buffer; in_ready = !buf_valid in every state, including during a sequence.
  - When the sequence would return to IDLE and buf_valid=1, go directly to SHIFT with the buffered word; done still pulses in that cycle.
  - Back-to-back period is COLS+1+SETTLE_CYC cycles.
  - A handshake in the same cycle the buffer drains: drain has priority and the new word is written to the buffer.
- Undefined: no buffer; in_ready = (state==IDLE); minimum period is COLS+2+SETTLE_CYC.

Decomposition:
- Shared package sipo_pkg:
  - state enum typedef (IDLE, SHIFT, LOAD, SETTLE), 2-bit.
  - default COLS constant, shared with sipo.
  - helper localparam for counter width.
- No sub-module for the FSM.
- Prefetch buffer is an optional sub-module sipo_word_buf (valid + data register) instantiated under the macro.
- Bench instantiates sipo_load_ctrl together with sipo and checks sipo.parallel_out.

Test Plan (COLS=16, SETTLE_CYC=2):
- Reset then single word 16'hA5C3 accepted at T → shift high T+1..T+16 with serial_out bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; load at T+17; SIPO parallel_out=16'hA5C3 at T+18; done at T+20.
- Walking-one 16'h0001 then 16'h8000 with in_valid held high → second word accepted in first done cycle; both appear correctly on the SIPO; no shift/load overlap.
- rst asserted at T+8 mid-shift → next cycle state IDLE, shift=0, busy=0, no load or done ever pulses; new word 16'hFFFF then completes normally.
- SETTLE_CYC=0, word 16'h1234 → done at T+18; in_ready low T+1..T+17.
- in_valid toggled with garbage in_data during busy → ignored; output word unchanged.
- PREFETCH_EN: three words 16'h1111, 16'h2222, 16'h3333 streamed → 2nd accepted at T+1; loads at T+17, T+36, T+55 (19-cycle period); done pulses at T+20, T+39, T+58; in_ready deasserts while the buffer is full.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared constants and FSM state type for the column SIPO and its load sequencer.
package sipo_pkg;

    localparam int SIPO_COLS = 16;

    function automatic int sipo_cnt_width(input int cols);
        return (cols > 1) ? $clog2(cols) : 1;
    endfunction

    localparam int SIPO_CNT_W = sipo_cnt_width(SIPO_COLS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_SETTLE = 2'd3
    } sipo_state_e;

endpackage

// File: rtl/sipo_load_ctrl_if.sv
// Upstream word handshake plus SIPO strobes and status of the load sequencer.
interface sipo_load_ctrl_if
    import sipo_pkg::*;
#(
    parameter int COLS = SIPO_COLS
);

    logic            in_valid;
    logic            in_ready;
    logic [COLS-1:0] in_data;
    logic            serial_out;
    logic            shift;
    logic            load;
    logic            busy;
    logic            done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  serial_out,
        input  shift,
        input  load,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output serial_out,
        output shift,
        output load,
        output busy,
        output done
    );

endinterface

// File: rtl/sipo.sv
// Column SIPO: MSB-first serial shift register with a separately loaded parallel output.
module sipo
    import sipo_pkg::*;
#(
    parameter int COLS = SIPO_COLS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            serial_in,
    input  logic            shift,
    input  logic            load,
    output logic [COLS-1:0] parallel_out
);

    logic [COLS-1:0] sr_q;
    logic [COLS-1:0] par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q  <= '0;
            par_q <= '0;
        end else begin
            if (shift) begin
                sr_q <= {sr_q[COLS-2:0], serial_in};
            end
            if (load) begin
                par_q <= sr_q;
            end
        end
    end

    assign parallel_out = par_q;

endmodule

// File: rtl/sipo_word_buf.sv
// One-entry word holding register used to prefetch the next column word.
module sipo_word_buf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // A write in the same cycle as a drain refills the entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (wr_i) begin
            valid_q <= 1'b1;
            data_q  <= wr_data_i;
        end else if (rd_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/sipo_load_ctrl.sv
// Column SIPO load sequencer: shift word MSB-first, pulse load, settle, report done.
// Define SIPO_LOAD_CTRL_PREFETCH_EN to add a one-entry word buffer for back-to-back streaming.
module sipo_load_ctrl
    import sipo_pkg::*;
#(
    parameter int COLS       = SIPO_COLS,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_load_ctrl_if.slave      bus
);

    localparam int CW = sipo_cnt_width(COLS);
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_TOP     = CW'(COLS - 1);
    localparam logic [SW-1:0] SETTLE_INIT = SW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    sipo_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [COLS-1:0] word_q, word_d;
    logic            done_q, done_d;

    logic            hs;
    logic            seq_end;
    logic            start_seq;
    logic [COLS-1:0] start_word;

`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
    logic            buf_valid;
    logic            buf_wr;
    logic            buf_rd;
    logic [COLS-1:0] buf_data;

    sipo_word_buf #(
        .W (COLS)
    ) u_word_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (buf_wr),
        .wr_data_i (bus.in_data),
        .rd_i      (buf_rd),
        .valid_o   (buf_valid),
        .data_o    (buf_data)
    );

    assign bus.in_ready = !buf_valid;
`else
    assign bus.in_ready = (state_q == ST_IDLE);
`endif

    assign hs      = bus.in_valid && bus.in_ready;
    assign seq_end = ((state_q == ST_LOAD) && (SETTLE_CYC == 0)) ||
                     ((state_q == ST_SETTLE) && (settle_q == '0));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        settle_d   = settle_q;
        word_d     = word_q;
        done_d     = 1'b0;
        start_seq  = 1'b0;
        start_word = bus.in_data;
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
        buf_wr     = 1'b0;
        buf_rd     = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
                if (buf_valid) begin
                    start_seq  = 1'b1;
                    start_word = buf_data;
                    buf_rd     = 1'b1;
                end else if (hs) begin
                    start_seq  = 1'b1;
                end
`else
                start_seq = hs;
`endif
            end
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LOAD: begin
                if (SETTLE_CYC > 0) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completion: with prefetch, chain straight into the next word instead of idling.
        if (seq_end) begin
            done_d = 1'b1;
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
            if (buf_valid) begin
                start_seq  = 1'b1;
                start_word = buf_data;
                buf_rd     = 1'b1;
                buf_wr     = hs;
            end else if (hs) begin
                start_seq  = 1'b1;
            end
`endif
        end
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
        else if (hs && (state_q != ST_IDLE)) begin
            buf_wr = 1'b1;
        end
`endif

        if (start_seq) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_TOP;
            word_d  = start_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            settle_q <= '0;
            word_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            word_q   <= word_d;
            done_q   <= done_d;
        end
    end

    assign bus.shift      = (state_q == ST_SHIFT);
    assign bus.load       = (state_q == ST_LOAD);
    assign bus.serial_out = (state_q == ST_SHIFT) ? word_q[cnt_q] : 1'b0;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Bench for sipo_load_ctrl + sipo at SETTLE_CYC=2 and SETTLE_CYC=0, against a timeline model.
module tb_sipo_load_ctrl;
    import sipo_pkg::*;

    localparam int COLS = 16;
    localparam int NDUT = 2;

    logic            clk;
    logic            rst;
    logic            inValid;
    logic [COLS-1:0] inData;
    logic [COLS-1:0] par0;
    logic [COLS-1:0] par1;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int t      = 0;
    bit modelOn = 1'b0;

    typedef struct {
        int              a;
        int              s;
        logic [COLS-1:0] w;
    } rec_t;

    rec_t hist [NDUT][512];
    int   nHist [NDUT];

    sipo_load_ctrl_if #(.COLS(COLS)) ifc0 ();
    sipo_load_ctrl_if #(.COLS(COLS)) ifc1 ();

    assign ifc0.in_valid = inValid;
    assign ifc0.in_data  = inData;
    assign ifc1.in_valid = inValid;
    assign ifc1.in_data  = inData;

    sipo_load_ctrl #(.COLS(COLS), .SETTLE_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    sipo_load_ctrl #(.COLS(COLS), .SETTLE_CYC(0)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    sipo #(.COLS(COLS)) sipo0 (
        .clk(clk), .rst(rst), .serial_in(ifc0.serial_out),
        .shift(ifc0.shift), .load(ifc0.load), .parallel_out(par0)
    );
    sipo #(.COLS(COLS)) sipo1 (
        .clk(clk), .rst(rst), .serial_in(ifc1.serial_out),
        .shift(ifc1.shift), .load(ifc1.load), .parallel_out(par1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int settleOf(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // A word accepted at a starts shifting at s; shift s..s+COLS-1, load s+COLS, done s+COLS+1+settle.
    task automatic computeExp(input int d,
                              output logic eShift, output logic eSer, output logic eLoad,
                              output logic eDone, output logic eBusy, output logic eReady,
                              output logic [COLS-1:0] ePar);
        int e;
        rec_t r;
        eShift = 1'b0; eSer = 1'b0; eLoad = 1'b0; eDone = 1'b0;
        eBusy = 1'b0; eReady = 1'b1; ePar = '0;
        for (int k = 0; k < nHist[d]; k++) begin
            r = hist[d][k];
            e = r.s + COLS + 1 + settleOf(d);
            if (t >= r.s && t < r.s + COLS) begin
                eShift = 1'b1;
                eSer   = r.w[COLS - 1 - (t - r.s)];
            end
            if (t == r.s + COLS) eLoad = 1'b1;
            if (t > r.s + COLS)  ePar  = r.w;
            if (t == e)          eDone = 1'b1;
            if (t >= r.s && t < e) eBusy = 1'b1;
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
            if (r.a < t && t < r.s) eReady = 1'b0;
`else
            if (r.a < t && t < e)   eReady = 1'b0;
`endif
        end
    endtask

    task automatic compareVal(input string tag, input int d,
                              input logic [COLS-1:0] obs, input logic [COLS-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s dut%0d cycle %0d: observed %h expected %h", tag, d, t, obs, exp);
        end
    endtask

    task automatic checkOutput(input int d, output logic expReady);
        logic eShift, eSer, eLoad, eDone, eBusy, eReady;
        logic [COLS-1:0] ePar;
        logic oShift, oSer, oLoad, oDone, oBusy, oReady;
        logic [COLS-1:0] oPar;
        computeExp(d, eShift, eSer, eLoad, eDone, eBusy, eReady, ePar);
        expReady = eReady;
        if (d == 0) begin
            oShift = ifc0.shift; oSer = ifc0.serial_out; oLoad = ifc0.load;
            oDone = ifc0.done; oBusy = ifc0.busy; oReady = ifc0.in_ready; oPar = par0;
        end else begin
            oShift = ifc1.shift; oSer = ifc1.serial_out; oLoad = ifc1.load;
            oDone = ifc1.done; oBusy = ifc1.busy; oReady = ifc1.in_ready; oPar = par1;
        end
        if (modelOn) begin
            compareVal("shift",      d, COLS'(oShift), COLS'(eShift));
            compareVal("serial_out", d, COLS'(oSer),   COLS'(eSer));
            compareVal("load",       d, COLS'(oLoad),  COLS'(eLoad));
            compareVal("done",       d, COLS'(oDone),  COLS'(eDone));
            compareVal("busy",       d, COLS'(oBusy),  COLS'(eBusy));
            compareVal("in_ready",   d, COLS'(oReady), COLS'(eReady));
            compareVal("parallel",   d, oPar,          ePar);
        end
    endtask

    // One clock cycle: drive inputs, check both DUTs mid-cycle, then advance the model.
    task automatic applyStimulus(input logic v, input logic [COLS-1:0] data, input logic r);
        logic rdy [NDUT];
        int   s;
        int   prevEnd;
        inValid = v;
        inData  = data;
        rst     = r;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput(d, rdy[d]);
            if (r) begin
                nHist[d] = 0;
            end else if (v && rdy[d]) begin
                s = t + 1;
`ifdef SIPO_LOAD_CTRL_PREFETCH_EN
                if (nHist[d] > 0) begin
                    prevEnd = hist[d][nHist[d]-1].s + COLS + 1 + settleOf(d);
                    if (prevEnd > s) s = prevEnd;
                end
`else
                prevEnd = 0;
`endif
                hist[d][nHist[d]] = '{a: t, s: s, w: data};
                nHist[d]++;
            end
        end
        if (r) modelOn = 1'b1;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    task automatic hold(input logic [COLS-1:0] data, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, data, 1'b0);
    endtask

    initial begin
        rst     = 1'b1;
        inValid = 1'b0;
        inData  = '0;
        nHist[0] = 0;
        nHist[1] = 0;
        @(posedge clk);
        #1;

        applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1);
        idle(2);

        $display("[TB] single word A5C3");
        applyStimulus(1'b1, 16'hA5C3, 1'b0);
        idle(23);

        $display("[TB] walking one, valid held");
        applyStimulus(1'b1, 16'h0001, 1'b0);
        hold(16'h8000, 20);
        idle(45);

        $display("[TB] reset mid-shift then FFFF");
        applyStimulus(1'b1, 16'hBEEF, 1'b0);
        idle(7);
        applyStimulus(1'b0, '0, 1'b1);
        idle(25);
        applyStimulus(1'b1, 16'hFFFF, 1'b0);
        idle(22);

        $display("[TB] 1234 with garbage while busy");
        applyStimulus(1'b1, 16'h1234, 1'b0);
        for (int i = 0; i < 19; i++) applyStimulus(1'($urandom_range(0, 1)), COLS'($urandom), 1'b0);
        idle(25);

        $display("[TB] three word stream");
        applyStimulus(1'b1, 16'h1111, 1'b0);
        hold(16'h2222, 20);
        hold(16'h3333, 20);
        idle(60);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 40), COLS'($urandom),
                          1'($urandom_range(0, 199) == 0));
        end
        idle(40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
